// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Optional opcode legality check enabled by defining ALU_ARB_OPCHECK_EN.
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [4*NREQ-1:0] req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [31:0]    r_a;
  logic [31:0]    r_b;
  logic [3:0]     r_op;
  logic [IDW-1:0] r_id;
  logic [31:0]    r_result;
  logic           r_zero;

  logic           w_found;
  logic [IDW-1:0] w_winner;
  int             w_cand;
  logic           w_grant;
  logic [31:0]    w_selA;
  logic [31:0]    w_selB;
  logic [3:0]     w_selOp;

  // Search upward from the last winner so it ends up with lowest priority.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = int'(r_ptr) + k;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      if (!w_found && req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = IDW'(w_cand);
      end
    end
  end

  assign w_grant   = rst_n && (r_state == S_IDLE) && w_found;
  assign req_ready = w_grant ? (NREQ'(1) << w_winner) : '0;
  assign w_selA    = req_a[32*int'(w_winner) +: 32];
  assign w_selB    = req_b[32*int'(w_winner) +: 32];
  assign w_selOp   = req_op[4*int'(w_winner) +: 4];

`ifdef ALU_ARB_OPCHECK_EN
  logic r_err;
  logic r_illegal;
  logic w_illegal;
  assign w_illegal = (w_selOp != OP_ADD) && (w_selOp != OP_SUB);
  assign rsp_err   = r_err;
`else
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= IDW'(NREQ - 1);
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_id     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      r_err     <= 1'b0;
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_id    <= w_winner;
            r_ptr   <= w_winner;
            r_state <= S_EXEC;
`ifdef ALU_ARB_OPCHECK_EN
            // Illegal ops still take the full path but feed a harmless add of zeros.
            r_illegal <= w_illegal;
            r_a       <= w_illegal ? 32'd0 : w_selA;
            r_b       <= w_illegal ? 32'd0 : w_selB;
            r_op      <= w_illegal ? OP_ADD : w_selOp;
`else
            r_a  <= w_selA;
            r_b  <= w_selB;
            r_op <= w_selOp;
`endif
          end
        end
        S_EXEC: begin
`ifdef ALU_ARB_OPCHECK_EN
          r_result <= r_illegal ? 32'd0 : alu_result;
          r_zero   <= r_illegal ? 1'b1 : alu_zero;
          r_err    <= r_illegal;
`else
          r_result <= alu_result;
          r_zero   <= alu_zero;
`endif
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_ctrl   = r_op;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_valid  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: random and directed requests, reference model
// predicts grants, latency and responses; a negedge monitor compares.
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      reqValid = '0;
  logic [NREQ-1:0]      reqReady;
  logic [32*NREQ-1:0]   reqA = '0;
  logic [32*NREQ-1:0]   reqB = '0;
  logic [4*NREQ-1:0]    reqOp = '0;
  logic                 rspValid;
  logic                 rspReady = 1'b0;
  logic [IDW-1:0]       rspId;
  logic [31:0]          rspResult;
  logic                 rspZero;
  logic                 rspErr;
  logic [31:0]          aluA;
  logic [31:0]          aluB;
  logic [3:0]           aluCtrl;
  logic [31:0]          aluResult;
  logic                 aluZero;
  logic                 busy;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_a(reqA), .req_b(reqB), .req_op(reqOp),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_id(rspId),
    .rsp_result(rspResult), .rsp_zero(rspZero), .rsp_err(rspErr),
    .alu_a(aluA), .alu_b(aluB), .alu_ctrl(aluCtrl),
    .alu_result(aluResult), .alu_zero(aluZero), .busy(busy)
  );

  // Stand-in for the shared ALU
  function automatic logic [31:0] aluFn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign aluResult = aluFn(aluCtrl, aluA, aluB);
  assign aluZero   = (aluResult == 32'd0);

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    result;
    logic           zero;
    logic           err;
  } rsp_t;

  rsp_t expQ[$];

  int checks = 0;
  int errors = 0;

  bit          mIdle = 1'b1;
  int          mPtr = NREQ - 1;
  int          cyc = 0;
  int          gCyc = 0;
  logic [31:0] mA = '0;
  logic [31:0] mB = '0;
  logic [3:0]  mOp = 4'b0010;
  bit          granted [NREQ];
  int          mode = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    reqValid[i]       = 1'b1;
    reqA[32*i +: 32]  = a;
    reqB[32*i +: 32]  = b;
    reqOp[4*i +: 4]   = op;
  endtask

  task automatic newReq(input int i);
    logic [3:0] ops [5];
    logic [31:0] a;
    ops = '{4'b0010, 4'b0110, 4'b0010, 4'b0000, 4'b0111};
    a = $urandom;
    applyStimulus(i, a, ($urandom_range(0, 3) == 0) ? a : $urandom, ops[$urandom_range(0, 4)]);
  endtask

  // Reference model and monitor: predicts grant, latency and response each cycle.
  always @(negedge clk) begin
    int w;
    int c;
    rsp_t e;
    if (!rst_n) begin
      checkOutput("rst_req_ready", reqReady, 0);
      checkOutput("rst_rsp_valid", rspValid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_rsp_id", rspId, 0);
      checkOutput("rst_rsp_result", rspResult, 0);
      checkOutput("rst_rsp_zero", rspZero, 0);
      checkOutput("rst_rsp_err", rspErr, 0);
      checkOutput("rst_alu_a", aluA, 0);
      checkOutput("rst_alu_b", aluB, 0);
      checkOutput("rst_alu_ctrl", aluCtrl, 32'h2);
      mIdle = 1'b1;
      mPtr  = NREQ - 1;
      expQ.delete();
      cyc = 0;
    end else begin
      cyc++;
      if (mIdle) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          c = (mPtr + k) % NREQ;
          if (w < 0 && reqValid[c]) w = c;
        end
        checkOutput("req_ready", reqReady, (w >= 0) ? (32'd1 << w) : 32'd0);
        checkOutput("busy_idle", busy, 0);
        checkOutput("rsp_valid_idle", rspValid, 0);
        if (w >= 0) begin
          mA  = reqA[32*w +: 32];
          mB  = reqB[32*w +: 32];
          mOp = reqOp[4*w +: 4];
          e.id  = IDW'(w);
          e.err = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
          if (mOp != 4'b0010 && mOp != 4'b0110) begin
            mA = '0; mB = '0; mOp = 4'b0010;
            e.err = 1'b1;
          end
`endif
          e.result = e.err ? 32'd0 : aluFn(mOp, mA, mB);
          e.zero   = (e.result == 32'd0);
          expQ.push_back(e);
          mPtr  = w;
          mIdle = 1'b0;
          gCyc  = cyc;
          granted[w] = 1'b1;
        end
      end else begin
        checkOutput("req_ready_busy", reqReady, 0);
        checkOutput("busy", busy, 1);
        if (cyc == gCyc + 1) begin
          checkOutput("alu_a", aluA, mA);
          checkOutput("alu_b", aluB, mB);
          checkOutput("alu_ctrl", aluCtrl, mOp);
        end
        checkOutput("rsp_valid", rspValid, (cyc >= gCyc + 2) ? 32'd1 : 32'd0);
        if (rspValid && cyc >= gCyc + 2) begin
          if (expQ.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL rsp_unexpected: got response id %0d expected none", rspId);
          end else begin
            e = expQ[0];
            checkOutput("rsp_id", rspId, e.id);
            checkOutput("rsp_result", rspResult, e.result);
            checkOutput("rsp_zero", rspZero, e.zero);
            checkOutput("rsp_err", rspErr, e.err);
            if (rspReady) begin
              void'(expQ.pop_front());
              mIdle = 1'b1;
            end
          end
        end
      end
    end
  end

  // Requester behaviour: granted requesters drop or reissue; random mode adds traffic.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (granted[i]) begin
        granted[i] = 1'b0;
        if (mode == 2) newReq(i);
        else reqValid[i] = 1'b0;
      end else if (mode == 1) begin
        if (!reqValid[i] && $urandom_range(0, 2) == 0) newReq(i);
        else if (reqValid[i] && $urandom_range(0, 19) == 0) reqValid[i] = 1'b0;
      end
    end
    if (mode == 1) rspReady = ($urandom_range(0, 2) != 0);
  end

  task automatic waitIdle(input int maxCyc);
    int n = 0;
    while (!(mIdle && reqValid == '0) && n < maxCyc) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= maxCyc) begin
      checks++; errors++;
      $display("[TB] FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
    @(posedge clk); #2;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    $display("[TB] single add");
    rspReady = 1'b1;
    applyStimulus(0, 32'd5, 32'd7, 4'b0010);
    waitIdle(20);

    $display("[TB] sub to zero and wrap");
    applyStimulus(0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0110);
    waitIdle(20);
    applyStimulus(1, 32'd0, 32'd1, 4'b0110);
    waitIdle(20);

    $display("[TB] contention");
    mode = 2;
    newReq(0);
    newReq(1);
    repeat (24) @(posedge clk);
    #2 mode = 0;
    waitIdle(30);

    $display("[TB] backpressure");
    rspReady = 1'b0;
    applyStimulus(0, 32'd100, 32'd23, 4'b0010);
    applyStimulus(1, 32'd9, 32'd4, 4'b0110);
    n = 0;
    while (!rspValid && n < 10) begin @(negedge clk); n++; end
    checkOutput("bp_rsp_valid_seen", rspValid, 1);
    repeat (5) @(posedge clk);
    #2 rspReady = 1'b1;
    waitIdle(30);

    $display("[TB] reset in exec");
    applyStimulus(1, 32'd11, 32'd22, 4'b0010);
    n = 0;
    while (mIdle && n < 10) begin @(negedge clk); #1; n++; end
    @(posedge clk); #2;
    rst_n = 1'b0;
    applyStimulus(0, 32'd1, 32'd2, 4'b0010);
    applyStimulus(1, 32'd3, 32'd4, 4'b0010);
    #1;
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_req_ready", reqReady, 0);
    checkOutput("async_rst_alu_ctrl", aluCtrl, 32'h2);
    checkOutput("async_rst_alu_a", aluA, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    waitIdle(30);

    $display("[TB] opcode 0000");
    applyStimulus(0, 32'h0F0F_1234, 32'h00FF_FFFF, 4'b0000);
    waitIdle(20);

    $display("[TB] random traffic");
    mode = 1;
    repeat (600) @(posedge clk);
    #2 mode = 0;
    rspReady = 1'b1;
    waitIdle(60);

    checkOutput("queue_empty", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
